// File: rtl/controller.sv
// Multicycle MIPS control unit.
// Moore FSM sequencing fetch / decode / execute / memory / writeback for
// R-type, lw, sw, beq and addi, plus an interrupt-entry state reached only
// at instruction boundaries. Every control output is registered: the output
// register is loaded with the decode of the state being entered, so the
// outputs always describe the state currently held in the state register.
// The current state is also driven out on fsm_state so it can be observed.

module controller #(
  // Cycles spent in the interrupt-entry state; only 1 is a legal value.
  parameter int VECTOR_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] funct,
  input  logic       INT,
  input  logic       NMI,
  input  logic       INTD,
  output logic       isBranch,
  output logic       PCWrite,
  output logic       lorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       INA,
  output logic [1:0] aluControl,
  output logic [1:0] ALUSrcB,
  output logic       PCSource,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       isInterrupted,
  output logic [3:0] fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_INTR   = 4'd11
  } state_t;

  typedef struct packed {
    logic       is_branch;
    logic       pc_write;
    logic       lor_d;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       ina;
    logic [1:0] alu_control;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       is_interrupted;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] INTR_LAST = 4'(VECTOR_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic       nmi_prev;
  logic       nmi_pending;
  logic       nmi_edge;
  logic       irq;
  logic       intr_done;
  logic [3:0] intr_cnt;

  // R-type function field to ALU operation; unknown functs fall back to add.
  function automatic logic [1:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'b100000: alu_from_funct = 2'b00;
      6'b100010: alu_from_funct = 2'b01;
      6'b100100: alu_from_funct = 2'b10;
      6'b100101: alu_from_funct = 2'b11;
      default:   alu_from_funct = 2'b00;
    endcase
  endfunction

  // Moore decode of a state into the full set of datapath controls.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: c.lor_d = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.lor_d     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_REXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = alu_from_funct(f);
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = 2'b01;
        c.is_branch   = 1'b1;
        c.pc_source   = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_INTR: begin
        c.ina            = 1'b1;
        c.is_interrupted = 1'b1;
        c.pc_write       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign nmi_edge  = NMI & ~nmi_prev;
  // Only the latched NMI counts at a boundary; an edge seen in the final
  // cycle of an instruction is serviced at the following boundary.
  assign irq       = nmi_pending | (INT & ~INTD);
  assign intr_done = (intr_cnt == INTR_LAST);

  // Next-state selection; every end-of-instruction exit checks for interrupts.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_REXEC;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = irq ? S_INTR : S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_REXEC:  state_nxt = S_RWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_ADDIWB:
        state_nxt = irq ? S_INTR : S_FETCH;
      S_INTR:   state_nxt = intr_done ? S_FETCH : S_INTR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State, registered outputs, NMI edge/pending latch and vector-cycle count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_FETCH;
      ctrl        <= ctrl_for(S_FETCH, funct);
      nmi_prev    <= 1'b0;
      nmi_pending <= 1'b0;
      intr_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_for(state_nxt, funct);
      nmi_prev <= NMI;
      // A fresh edge wins over the clear done by the interrupt-entry state.
      if (nmi_edge)
        nmi_pending <= 1'b1;
      else if (state == S_INTR)
        nmi_pending <= 1'b0;
      if (state == S_INTR && !intr_done)
        intr_cnt <= intr_cnt + 4'd1;
      else
        intr_cnt <= '0;
    end
  end

  assign isBranch      = ctrl.is_branch;
  assign PCWrite       = ctrl.pc_write;
  assign lorD          = ctrl.lor_d;
  assign MemWrite      = ctrl.mem_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign IRWrite       = ctrl.ir_write;
  assign INA           = ctrl.ina;
  assign aluControl    = ctrl.alu_control;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign RegWrite      = ctrl.reg_write;
  assign RegDst        = ctrl.reg_dst;
  assign isInterrupted = ctrl.is_interrupted;
  assign fsm_state     = state;

endmodule

// File: tb/tb_controller.sv
// Bench for the multicycle MIPS controller. Each instruction's expected
// per-cycle control vectors are queued when the opcode is driven and popped
// one per cycle as the controller steps through the instruction.

module tb_controller;

  logic       Clk;
  logic       Reset;
  logic [5:0] Op;
  logic [5:0] funct;
  logic       INT;
  logic       NMI;
  logic       INTD;
  logic       isBranch;
  logic       PCWrite;
  logic       lorD;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       INA;
  logic [1:0] aluControl;
  logic [1:0] ALUSrcB;
  logic       PCSource;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       isInterrupted;
  logic [3:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];

  // Bench-side state names for building expected sequences.
  localparam int T_FETCH  = 0;
  localparam int T_DECODE = 1;
  localparam int T_MEMADR = 2;
  localparam int T_MEMRD  = 3;
  localparam int T_MEMWB  = 4;
  localparam int T_MEMWR  = 5;
  localparam int T_REXEC  = 6;
  localparam int T_RWB    = 7;
  localparam int T_BEQ    = 8;
  localparam int T_ADDIEX = 9;
  localparam int T_ADDIWB = 10;
  localparam int T_INTR   = 11;

  controller dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .funct(funct),
    .INT(INT), .NMI(NMI), .INTD(INTD),
    .isBranch(isBranch), .PCWrite(PCWrite), .lorD(lorD),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .INA(INA), .aluControl(aluControl), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .isInterrupted(isInterrupted), .fsm_state(fsm_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] observed();
    return {isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, INA,
            aluControl, ALUSrcB, PCSource, ALUSrcA, RegWrite, RegDst,
            isInterrupted};
  endfunction

  // Reference control vector for a state, written from the control tables.
  function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] fn);
    logic ib, pw, lrd, mw, m2r, irw, ina, pcs, asa, rw, rd, isi;
    logic [1:0] alu, asb;
    {ib, pw, lrd, mw, m2r, irw, ina, pcs, asa, rw, rd, isi} = '0;
    alu = 2'b00;
    asb = 2'b00;
    case (s)
      T_FETCH:  begin irw = 1; pw = 1; asb = 2'b01; end
      T_DECODE: asb = 2'b11;
      T_MEMADR: begin asa = 1; asb = 2'b10; end
      T_MEMRD:  lrd = 1;
      T_MEMWB:  begin rw = 1; m2r = 1; end
      T_MEMWR:  begin lrd = 1; mw = 1; end
      T_REXEC: begin
        asa = 1;
        if (fn == 6'b100010) alu = 2'b01;
        else if (fn == 6'b100100) alu = 2'b10;
        else if (fn == 6'b100101) alu = 2'b11;
        else alu = 2'b00;
      end
      T_RWB:    begin rw = 1; rd = 1; end
      T_BEQ:    begin asa = 1; alu = 2'b01; ib = 1; pcs = 1; end
      T_ADDIEX: begin asa = 1; asb = 2'b10; end
      T_ADDIWB: rw = 1;
      T_INTR:   begin ina = 1; isi = 1; pw = 1; end
      default: ;
    endcase
    return {ib, pw, lrd, mw, m2r, irw, ina, alu, asb, pcs, asa, rw, rd, isi};
  endfunction

  // Driver: issue one instruction from a FETCH negedge and check every cycle.
  // nmi_step pulses NMI for one cycle after that step; abort_step asserts
  // Reset after that step and truncates the expected sequence there.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input bit expect_intr,
                           input int nmi_step, input int abort_step);
    int seq[$];
    int n;
    logic [15:0] exp;
    logic [15:0] obs;
    Op = op;
    funct = fn;
    case (op)
      6'b100011: seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB};
      6'b101011: seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWR};
      6'b000000: seq = '{T_FETCH, T_DECODE, T_REXEC, T_RWB};
      6'b000100: seq = '{T_FETCH, T_DECODE, T_BEQ};
      6'b001000: seq = '{T_FETCH, T_DECODE, T_ADDIEX, T_ADDIWB};
      default:   seq = '{T_FETCH, T_DECODE};
    endcase
    if (abort_step >= 0) begin
      while (seq.size() > abort_step + 1) void'(seq.pop_back());
    end else if (expect_intr) begin
      seq.push_back(T_INTR);
    end
    foreach (seq[i]) exp_q.push_back(exp_ctrl(seq[i], fn));
    n = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, n, obs, exp);
      end
      NMI = (n == nmi_step);
      if (n == abort_step) Reset = 1'b1;
      n++;
      @(negedge Clk);
    end
    NMI = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    Reset = 1'b1;
    Op = 6'b0; funct = 6'b0; INT = 1'b0; NMI = 1'b0; INTD = 1'b0;
    repeat (3) @(negedge Clk);
    exp = exp_ctrl(T_FETCH, 6'b0);
    n_checks++;
    if (observed() !== exp) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", observed(), exp);
    end
    Reset = 1'b0;
  endtask

  task automatic test_lw();
    run_instr("lw", 6'b100011, 6'b0, 1'b0, -1, -1);
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111000};
    foreach (fns[i]) run_instr("rtype", 6'b000000, fns[i], 1'b0, -1, -1);
  endtask

  task automatic test_beq_sw();
    run_instr("beq", 6'b000100, 6'($urandom_range(0, 63)), 1'b0, -1, -1);
    run_instr("sw", 6'b101011, 6'b0, 1'b0, -1, -1);
    run_instr("addi", 6'b001000, 6'b0, 1'b0, -1, -1);
  endtask

  task automatic test_unsupported();
    run_instr("unsup_j", 6'b000010, 6'b0, 1'b0, -1, -1);
    run_instr("unsup_rand", 6'($urandom_range(48, 63)), 6'b0, 1'b0, -1, -1);
  endtask

  task automatic test_int();
    INT = 1'b1; INTD = 1'b0;
    run_instr("int_addi", 6'b001000, 6'b0, 1'b1, -1, -1);
    INT = 1'b1; INTD = 1'b1;
    run_instr("int_masked", 6'b001000, 6'b0, 1'b0, -1, -1);
    INT = 1'b0; INTD = 1'b0;
  endtask

  task automatic test_nmi();
    INT = 1'b1; INTD = 1'b1;
    run_instr("nmi_lw", 6'b100011, 6'b0, 1'b1, 2, -1);
    run_instr("nmi_after", 6'b001000, 6'b0, 1'b0, -1, -1);
    INT = 1'b0; INTD = 1'b0;
  endtask

  task automatic test_back_to_back();
    INT = 1'b1; INTD = 1'b0;
    run_instr("b2b_sw_nmi", 6'b101011, 6'b0, 1'b1, 1, -1);
    run_instr("b2b_unsup_int", 6'b111111, 6'b0, 1'b1, -1, -1);
    INT = 1'b0;
    run_instr("b2b_beq_clear", 6'b000100, 6'b0, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_instr("abort_lw", 6'b100011, 6'b0, 1'b0, 1, 2);
    run_instr("after_abort", 6'b001000, 6'b0, 1'b0, -1, -1);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq_sw();
    test_unsupported();
    test_int();
    test_nmi();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback for a small MIPS subset.
- Adds an interrupt-entry cycle for a maskable interrupt (INT, masked by INTD) and a non-maskable interrupt (NMI).
- Drives all datapath mux selects, write enables and ALU operation codes of the multicycle datapath.

Parameters:
- VECTOR_CYCLES, 1, number of cycles spent in the interrupt-entry state (fixed at 1; any other value is illegal).

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Op  in  6  instruction opcode (IR[31:26])
- funct  in  6  R-type function field (IR[5:0])
- INT  in  1  maskable interrupt request, level
- NMI  in  1  non-maskable interrupt request, rising-edge detected
- INTD  in  1  interrupt disable; 1 masks INT
- isBranch  out  1  conditional PC write; datapath PC enable = PCWrite | (isBranch & Zero)
- PCWrite  out  1  unconditional PC write
- lorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- IRWrite  out  1  instruction register load
- INA  out  1  interrupt acknowledge
- aluControl  out  2  00 add, 01 sub, 10 and, 11 or
- ALUSrcB  out  2  00 = B reg, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- PCSource  out  1  PC input: 0 = ALU result, 1 = ALUOut
- ALUSrcA  out  1  0 = PC, 1 = A reg
- RegWrite  out  1  register file write
- RegDst  out  1  write register: 0 = rt, 1 = rd
- isInterrupted  out  1  high in interrupt-entry cycle; datapath loads the interrupt vector into PC

Behaviour:
- All outputs are Moore functions of state; any output not listed for a state is 0.
- Reset (synchronous, wins over everything): state = FETCH, NMI pending flag cleared, NMI edge register cleared.
- Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi.
- Any other opcode returns DECODE -> FETCH with no writes.
- R-type funct mapping: 100000 -> 00, 100010 -> 01, 100100 -> 10, 100101 -> 11; any other funct -> 00.
- FETCH: IRWrite=1, PCWrite=1, lorD=0, ALUSrcA=0, ALUSrcB=01, aluControl=00, PCSource=0. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, aluControl=00 (branch target into ALUOut). Next state by Op:
  - lw/sw -> MEMADR
  - R-type -> REXEC
  - beq -> BEQ
  - addi -> ADDIEX
- MEMADR: ALUSrcA=1, ALUSrcB=10, aluControl=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: lorD=1. Next state MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. End of instruction.
- MEMWR: lorD=1, MemWrite=1. End of instruction.
- REXEC: ALUSrcA=1, ALUSrcB=00, aluControl from funct. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. End of instruction.
- BEQ: ALUSrcA=1, ALUSrcB=00, aluControl=01, isBranch=1, PCSource=1. End of instruction.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, aluControl=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. End of instruction.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, unsupported opcode 2.
- NMI edge detection: a rising edge of NMI (previous sample 0, current 1) sets nmi_pending.
- Interrupt check at end of instruction, including the unsupported-opcode DECODE exit:
  - pending = nmi_pending | (INT & ~INTD)
  - pending -> INTR, otherwise -> FETCH
- Interrupts are never taken mid-instruction.
- INTR (one cycle): INA=1, isInterrupted=1, PCWrite=1. Next state FETCH.
- INTR clears nmi_pending if set (NMI has priority over INT). If both NMI and INT are pending, the INT is serviced on a later boundary if still asserted and unmasked.
- An NMI edge arriving in the same cycle it is cleared re-sets nmi_pending (set wins).
- INT with INTD=1 is ignored.
- Reset asserted mid-instruction aborts it; the next state is FETCH.

Test Plan:
- Reset, then Op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMRD has lorD=1; MEMWB has RegWrite=1, MemtoReg=1. Next FETCH at cycle 6.
- Op=000000, funct=100010 -> REXEC shows aluControl=01, ALUSrcA=1, ALUSrcB=00. RWB shows RegWrite=1, RegDst=1. 4 cycles total.
- Op=000100 (beq) -> 3rd cycle has isBranch=1, PCSource=1, aluControl=01, PCWrite=0. Op=101011 (sw) -> MemWrite=1 in 4th cycle only.
- INT=1, INTD=0 during addi -> after ADDIWB, one cycle with INA=1, isInterrupted=1, PCWrite=1, then FETCH. Repeat with INTD=1 -> no INTR cycle.
- 1-cycle NMI pulse mid-lw with INTD=1 -> INTR follows MEMWB exactly once; the following instruction is not interrupted.
- Assert Reset in MEMADR -> next cycle is FETCH with IRWrite=1, PCWrite=1; pending NMI is discarded.
